uart_receiver_system: RTL

UART receive-side counterpart to the transmitter system. Deserialises 8-bit frames from a single serial line at a fixed baud and hands each byte to local logic with a ready/acknowledge handshake. Maintains a running CRC-8 over all accepted bytes so the host-side display logic can show the checksum and compare it against the transmitter's.

---
 rtl/uart_receiver_system_pkg.sv | 19 +
 rtl/crc8_byte_update.sv | 23 ++
 rtl/uart_receiver_system.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_system_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings, the default
// CRC-8 polynomial and the CRC initial value.
// Optional build macro used by the receiver: UART_RX_PARITY_EN (8E1 framing).
package uart_receiver_system_pkg;

  // Fixed encodings keep receiver and transmitter debug views consistent.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic [7:0] DEFAULT_CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT         = 8'h00;

endpackage

// File: rtl/crc8_byte_update.sv
// Combinational CRC-8 step over one byte, MSB-first, no reflection.
// Shared between the UART receiver and transmitter sides.
module crc8_byte_update (
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  input  logic [7:0] poly,
  output logic [7:0] crc_out
);

  function automatic logic [7:0] crc_step(input logic [7:0] c,
                                          input logic [7:0] b,
                                          input logic [7:0] p);
    logic [7:0] acc;
    acc = c ^ b;
    for (int i = 0; i < 8; i++) begin
      acc = acc[7] ? ((acc << 1) ^ p) : (acc << 1);
    end
    return acc;
  endfunction

  assign crc_out = crc_step(crc_in, byte_in, poly);

endmodule

// File: rtl/uart_receiver_system.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM, byte
// handshake with overrun detection and a running CRC-8 over accepted bytes.
// Build macro UART_RX_PARITY_EN selects 8E1 framing and adds parity_error;
// without it the receiver is 8N1.
module uart_receiver_system
  import uart_receiver_system_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] CRC_POLY     = DEFAULT_CRC_POLY
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       data_in,
  input  logic       acknowledge,
  input  logic       clear,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic [7:0] crc8,
  output logic [7:0] byte_count,
  output logic       frame_error,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync1, rxs;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       crc_base, crc_next;
  logic             parity_ok;
  logic             data_tick;

  assign data_tick = (state == DATA) && (cnt == BIT_LAST);

  // A clear coinciding with an accept restarts the CRC from the init value.
  assign crc_base = clear ? CRC_INIT : crc8;

  crc8_byte_update u_crc (
    .crc_in  (crc_base),
    .byte_in (shift_reg),
    .poly    (CRC_POLY),
    .crc_out (crc_next)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Capture the parity bit at its mid-bit sample point.
  always_ff @(posedge clock) begin
    if ((state == PARITY) && (cnt == BIT_LAST)) par_bit <= rxs;
  end

  assign parity_ok = ~^{shift_reg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Two-flop synchroniser on the serial line; idles high out of reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= data_in;
      rxs   <= sync1;
    end
  end

  // Data shift register, LSB arrives first so bits enter from the top.
  always_ff @(posedge clock) begin
    if (data_tick) shift_reg <= {rxs, shift_reg[7:1]};
  end

  // Frame FSM with baud counter, handshake, CRC/count and error flags.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      data_out     <= 8'h00;
      data_ready   <= 1'b0;
      crc8         <= CRC_INIT;
      byte_count   <= 8'd0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (acknowledge && data_ready) data_ready <= 1'b0;
      if (clear) begin
        crc8       <= CRC_INIT;
        byte_count <= 8'd0;
        overrun    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            parity_error <= ~parity_ok;
`endif
            if (rxs) begin
              state <= IDLE;
              if (parity_ok) begin
                data_out   <= shift_reg;
                data_ready <= 1'b1;
                crc8       <= crc_next;
                byte_count <= (clear ? 8'd0 : byte_count) + 8'd1;
                if (data_ready && !acknowledge) overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
